// File: rtl/reg_file.sv
// reg_file: general-purpose register file on the writeback side of the core.
//   Write port  : Addr/Data/wr_en/w_mode. Modes are word (0), halfword (1),
//                 byte (2) and reserved (3, no write). Narrow writes keep the
//                 untouched upper bits.
//   Read ports  : rd_addr_a/b -> rd_data_a/b. These are combinational, and a
//                 write in the same cycle is bypassed to them.
//   Dump port   : after Halt the contents freeze. Each register is then
//                 streamed out over dump_valid/dump_ready with dump_addr and
//                 dump_data. dump_done stays high once the last beat has
//                 been accepted.
//   clk/rst_n   : posedge clock, asynchronous active-low reset.
// r0 is hardwired to zero on every path.
module reg_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 5,
  parameter int NREGS    = 2**ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] Addr,
  input  logic [WIDTH-1:0]    Data,
  input  logic                wr_en,
  input  logic [1:0]          w_mode,
  input  logic                Halt,
  input  logic [ADDR_LEN-1:0] rd_addr_a,
  output logic [WIDTH-1:0]    rd_data_a,
  input  logic [ADDR_LEN-1:0] rd_addr_b,
  output logic [WIDTH-1:0]    rd_data_b,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [ADDR_LEN-1:0] dump_addr,
  output logic [WIDTH-1:0]    dump_data,
  output logic                dump_done
);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_e;

  localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(NREGS-1);

  state_e                         state_q, state_d;
  logic [NREGS-1:0][WIDTH-1:0]    regs_q, regs_d;
  logic                           dump_valid_q, dump_valid_d;
  logic                           dump_done_q, dump_done_d;
  // The dump address register doubles as the dump index.
  logic [ADDR_LEN-1:0]            dump_addr_q, dump_addr_d;
  logic [WIDTH-1:0]               dump_data_q, dump_data_d;

  logic                           wr_hit;
  logic [WIDTH-1:0]               wr_old, wr_merged;
  logic [ADDR_LEN-1:0]            next_idx;

  // Merge the incoming write with the current contents. The same value
  // feeds both the commit and the read bypass.
  always_comb begin
    wr_hit = wr_en && (state_q == S_IDLE) && (w_mode != 2'd3) && (Addr != '0);
    wr_old = regs_q[Addr];
    unique case (w_mode)
      2'd0:    wr_merged = Data;
      2'd1:    wr_merged = {wr_old[WIDTH-1:16], Data[15:0]};
      2'd2:    wr_merged = {wr_old[WIDTH-1:8],  Data[7:0]};
      default: wr_merged = wr_old;
    endcase
  end

  // wr_hit already excludes Addr==0, so the bypass can never leak into r0.
  assign rd_data_a = (rd_addr_a == '0) ? '0 :
                     (wr_hit && rd_addr_a == Addr) ? wr_merged : regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 :
                     (wr_hit && rd_addr_b == Addr) ? wr_merged : regs_q[rd_addr_b];

  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    dump_valid_d = dump_valid_q;
    dump_done_d  = dump_done_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    next_idx     = dump_addr_q + 1'b1;

    if (wr_hit) regs_d[Addr] = wr_merged;
    regs_d[0] = '0;

    unique case (state_q)
      S_IDLE: begin
        // A write in the Halt cycle still commits. Beat 0 is r0, so its
        // data is zero regardless of that write.
        if (Halt) begin
          state_d      = S_DUMP;
          dump_valid_d = 1'b1;
          dump_addr_d  = '0;
          dump_data_d  = '0;
        end
      end
      S_DUMP: begin
        // Contents are frozen here, so preloading the next beat from regs_q
        // is safe.
        if (dump_ready) begin
          if (dump_addr_q == LAST_IDX) begin
            state_d      = S_DONE;
            dump_valid_d = 1'b0;
            dump_done_d  = 1'b1;
            dump_addr_d  = '0;
            dump_data_d  = '0;
          end else begin
            dump_addr_d = next_idx;
            dump_data_d = regs_q[next_idx];
          end
        end
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      regs_q       <= '0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
    end
  end

  assign dump_valid = dump_valid_q;
  assign dump_done  = dump_done_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized self-checking bench for reg_file.
// The reference model is an array of register values updated with mask
// arithmetic, plus a "frozen" flag that is set by Halt and cleared by reset.
module tb_reg_file;
  localparam int W  = 32;
  localparam int AL = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AL-1:0] Addr = '0;
  logic [W-1:0]  Data = '0;
  logic          wr_en = 1'b0;
  logic [1:0]    w_mode = '0;
  logic          Halt = 1'b0;
  logic [AL-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          dump_valid, dump_ready = 1'b0, dump_done;
  logic [AL-1:0] dump_addr;
  logic [W-1:0]  dump_data;

  reg_file #(.WIDTH(W), .ADDR_LEN(AL), .NREGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .Data(Data), .wr_en(wr_en),
    .w_mode(w_mode), .Halt(Halt), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [N];
  bit          frozen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] m);
    logic [31:0] mask;
    case (m)
      2'd0:    mask = 32'hFFFF_FFFF;
      2'd1:    mask = 32'h0000_FFFF;
      2'd2:    mask = 32'h0000_00FF;
      default: mask = 32'h0000_0000;
    endcase
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [AL-1:0] ra);
    if (ra == 0) return 32'h0;
    if (!frozen && wr_en && Addr == ra) return merge(model[ra], Data, w_mode);
    return model[ra];
  endfunction

  // One clock cycle: drive inputs, check both reads before the edge, then
  // apply the write to the model.
  task automatic cyc(input bit wr, input logic [AL-1:0] a, input logic [31:0] d,
                     input logic [1:0] m, input bit h,
                     input logic [AL-1:0] ra, input logic [AL-1:0] rb);
    wr_en = wr; Addr = a; Data = d; w_mode = m; Halt = h;
    rd_addr_a = ra; rd_addr_b = rb; dump_ready = 1'b0;
    #1;
    chk("rd_a", rd_data_a, exp_rd(ra));
    chk("rd_b", rd_data_b, exp_rd(rb));
    @(posedge clk);
    if (!frozen && wr && a != 0) model[a] = merge(model[a], d, m);
    if (h) frozen = 1'b1;
    #1;
  endtask

  task automatic rd_const(input string tag, input logic [AL-1:0] ra, input logic [31:0] exp);
    wr_en = 1'b0; Halt = 1'b0; rd_addr_a = ra; rd_addr_b = ra;
    #1;
    chk(tag, rd_data_a, exp);
    chk(tag, rd_data_b, exp);
  endtask

  task automatic clear_model();
    foreach (model[i]) model[i] = 32'h0;
    frozen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; Halt = 1'b0; dump_ready = 1'b0;
    Addr = '0; Data = '0; w_mode = '0; rd_addr_a = '0; rd_addr_b = '0;
    #2;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive the dump sink. mode 0: ready always high; 1: ready pattern
  // 1,0,0,1; 2: random. Random writes and Halt run alongside and must have
  // no effect. stop_at >= 0 returns once that many beats have been accepted.
  task automatic run_dump(input int mode, input int stop_at);
    int  idx = 0;
    int  cycles = 0;
    bit  r;
    while (idx < N && cycles < 400 && idx != stop_at) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = (cycles % 4 == 0) || (cycles % 4 == 3);
      else                r = 1'($urandom_range(0, 1));
      dump_ready = r;
      wr_en = 1'($urandom_range(0, 1)); Addr = 5'($urandom); Data = $urandom;
      w_mode = 2'($urandom); Halt = 1'($urandom_range(0, 1));
      rd_addr_a = Addr; rd_addr_b = 5'($urandom);
      #1;
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_addr", 32'(dump_addr), 32'(idx));
      chk("dump_data", dump_data, model[idx]);
      chk("dump_done_early", 32'(dump_done), 32'd0);
      chk("rd_a_frozen", rd_data_a, exp_rd(rd_addr_a));
      chk("rd_b_frozen", rd_data_b, exp_rd(rd_addr_b));
      @(posedge clk);
      if (r) idx++;
      cycles++;
      #1;
    end
    if (stop_at < 0) begin
      chk("dump_beats", 32'(idx), 32'(N));
      if (mode == 0) chk("dump_len", 32'(cycles), 32'(N));
      dump_ready = 1'b0; wr_en = 1'b0; Halt = 1'b0;
      #1;
      chk("done_valid", 32'(dump_valid), 32'd0);
      chk("done_flag", 32'(dump_done), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AL-1:0] a;
    logic [AL-1:0] ra;

    // Reset state.
    do_reset();
    for (int i = 0; i < N; i++) rd_const("reset_rd", 5'(i), 32'h0);
    chk("reset_valid", 32'(dump_valid), 32'd0);
    chk("reset_done", 32'(dump_done), 32'd0);
    chk("reset_addr", 32'(dump_addr), 32'd0);
    chk("reset_data", dump_data, 32'h0);

    // Word, halfword, byte and reserved-mode writes.
    cyc(1, 5'd3, 32'hDEADBEEF, 2'd0, 0, 5'd3, 5'd0);
    rd_const("w_word", 5'd3, 32'hDEADBEEF);
    cyc(1, 5'd3, 32'h00001234, 2'd1, 0, 5'd3, 5'd3);
    rd_const("w_half", 5'd3, 32'hDEAD1234);
    cyc(1, 5'd3, 32'h000000AB, 2'd2, 0, 5'd3, 5'd1);
    rd_const("w_byte", 5'd3, 32'hDEAD12AB);
    cyc(1, 5'd3, 32'hFFFFFFFF, 2'd3, 0, 5'd3, 5'd3);
    rd_const("w_resv", 5'd3, 32'hDEAD12AB);

    // Writes to r0 are discarded, including on the bypass path.
    wr_en = 1'b1; Addr = 5'd0; Data = 32'hFFFFFFFF; w_mode = 2'd0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    chk("r0_bypass", rd_data_a, 32'h0);
    @(posedge clk); #1;
    rd_const("r0_after", 5'd0, 32'h0);

    // Same-cycle bypass of a byte write.
    cyc(1, 5'd7, 32'h11112222, 2'd0, 0, 5'd0, 5'd0);
    wr_en = 1'b1; Addr = 5'd7; Data = 32'h00000099; w_mode = 2'd2;
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #1;
    chk("bypass_a", rd_data_a, 32'h11112299);
    chk("bypass_b", rd_data_b, 32'h11112299);
    @(posedge clk);
    model[7] = 32'h11112299;
    #1;
    rd_const("bypass_commit", 5'd7, 32'h11112299);

    // Randomized write/read traffic.
    repeat (300) begin
      a  = 5'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? a : 5'($urandom);
      cyc(($urandom_range(0, 3) != 0), a, $urandom, 2'($urandom), 0, ra, 5'($urandom));
    end
    for (int i = 0; i < N; i++) cyc(0, 5'd0, 32'h0, 2'd0, 0, 5'(i), 5'(N-1-i));

    // Full-rate dump with a one-cycle Halt and writes during the dump.
    cyc(1, 5'd31, 32'hCAFEF00D, 2'd0, 0, 5'd0, 5'd0);
    cyc(0, 5'd0, 32'h0, 2'd0, 1, 5'd31, 5'd31);
    run_dump(0, -1);
    rd_const("r31_dumped", 5'd31, 32'hCAFEF00D);
    repeat (10) begin
      cyc(1, 5'($urandom), $urandom, 2'($urandom), 1'($urandom_range(0, 1)),
          5'($urandom), 5'($urandom));
      chk("post_done_valid", 32'(dump_valid), 32'd0);
      chk("post_done_flag", 32'(dump_done), 32'd1);
    end

    // Dump with ready toggling 1,0,0,1.
    do_reset();
    repeat (40) cyc(1, 5'($urandom), $urandom, 2'($urandom), 0, 5'($urandom), 5'($urandom));
    cyc(0, 5'd0, 32'h0, 2'd0, 1, 5'd0, 5'd0);
    run_dump(1, -1);

    // Reset in the middle of a dump.
    do_reset();
    repeat (20) cyc(1, 5'($urandom), $urandom, 2'd0, 0, 5'($urandom), 5'($urandom));
    cyc(0, 5'd0, 32'h0, 2'd0, 1, 5'd0, 5'd0);
    run_dump(0, 5);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("mid_rst_valid", 32'(dump_valid), 32'd0);
    chk("mid_rst_done", 32'(dump_done), 32'd0);
    chk("mid_rst_addr", 32'(dump_addr), 32'd0);
    chk("mid_rst_data", dump_data, 32'h0);
    for (int i = 0; i < N; i++) rd_const("mid_rst_rd", 5'(i), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Writes are accepted again and a new dump restarts at index 0.
    cyc(1, 5'd9, 32'h5A5A5A5A, 2'd0, 0, 5'd0, 5'd0);
    rd_const("idle_after_rst", 5'd9, 32'h5A5A5A5A);
    cyc(0, 5'd0, 32'h0, 2'd0, 1, 5'd9, 5'd0);
    run_dump(2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
